// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter for one shared Data_Memory port.
// Requester 0 is the dcache, requester 1 is instruction fetch.
// The optional macro MEM_ARB_RR_EN selects round-robin on simultaneous
// requests. Without it, m0 always wins a tie and no last-owner state exists.
// Every completion is followed by at least one IDLE cycle, because a grant
// can only be issued from IDLE.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              m0_enable_i,
    input  logic              m0_write_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_data_i,
    output logic              m0_ack_o,
    output logic [DATA_W-1:0] m0_data_o,

    input  logic              m1_enable_i,
    input  logic              m1_write_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_data_i,
    output logic              m1_ack_o,
    output logic [DATA_W-1:0] m1_data_o,

    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_data_i,

    output logic [1:0]        grant_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state, state_nxt;

`ifdef MEM_ARB_RR_EN
    // 1 when m1 owned the port most recently; on a tie the other requester wins
    logic last_owner;
`endif

    // Choose the next owner in IDLE, and release the port when memory acks
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (m0_enable_i && m1_enable_i) begin
`ifdef MEM_ARB_RR_EN
                    state_nxt = last_owner ? GNT0 : GNT1;
`else
                    state_nxt = GNT0;
`endif
                end else if (m0_enable_i) begin
                    state_nxt = GNT0;
                end else if (m1_enable_i) begin
                    state_nxt = GNT1;
                end
            end
            GNT0, GNT1: begin
                if (mem_ack_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and registered memory-side outputs. Request fields are captured
    // once on grant, held until release, and cleared in IDLE.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state        <= IDLE;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
            grant_o      <= 2'b00;
        end else begin
            state        <= state_nxt;
            mem_enable_o <= (state_nxt != IDLE);
            grant_o      <= {state_nxt == GNT1, state_nxt == GNT0};
            if (state == IDLE && state_nxt == GNT0) begin
                mem_write_o <= m0_write_i;
                mem_addr_o  <= m0_addr_i;
                mem_data_o  <= m0_data_i;
            end else if (state == IDLE && state_nxt == GNT1) begin
                mem_write_o <= m1_write_i;
                mem_addr_o  <= m1_addr_i;
                mem_data_o  <= m1_data_i;
            end else if (state_nxt == IDLE) begin
                mem_write_o <= 1'b0;
                mem_addr_o  <= '0;
                mem_data_o  <= '0;
            end
        end
    end

`ifdef MEM_ARB_RR_EN
    // Remember who was granted last so a tie alternates
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            last_owner <= 1'b1;
        end else if (state == IDLE && state_nxt == GNT0) begin
            last_owner <= 1'b0;
        end else if (state == IDLE && state_nxt == GNT1) begin
            last_owner <= 1'b1;
        end
    end
`endif

    // Acks reach only the current owner. They are suppressed while reset is
    // asserted, so an abandoned transaction never completes.
    assign m0_ack_o  = rst_i & mem_ack_i & (state == GNT0);
    assign m1_ack_o  = rst_i & mem_ack_i & (state == GNT1);
    assign m0_data_o = mem_data_i;
    assign m1_data_o = mem_data_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter. The bench drives inputs
// 1 ns after each rising edge and checks the outputs after that.
module tb_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 256;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              m0_enable_i, m0_write_i, m1_enable_i, m1_write_i;
    logic [ADDR_W-1:0] m0_addr_i, m1_addr_i, mem_addr_o;
    logic [DATA_W-1:0] m0_data_i, m1_data_i, m0_data_o, m1_data_o;
    logic [DATA_W-1:0] mem_data_o, mem_data_i;
    logic              m0_ack_o, m1_ack_o, mem_enable_o, mem_write_o, mem_ack_i;
    logic [1:0]        grant_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_enable_i(m0_enable_i), .m0_write_i(m0_write_i),
        .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i),
        .m0_ack_o(m0_ack_o), .m0_data_o(m0_data_o),
        .m1_enable_i(m1_enable_i), .m1_write_i(m1_write_i),
        .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i),
        .m1_ack_o(m1_ack_o), .m1_data_o(m1_data_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
        .grant_o(grant_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        m0_enable_i = 0; m0_write_i = 0; m0_addr_i = '0; m0_data_i = '0;
        m1_enable_i = 0; m1_write_i = 0; m1_addr_i = '0; m1_data_i = '0;
        mem_ack_i = 0; mem_data_i = '0;
        tick(); tick();
        checks++;
        if (mem_enable_o !== 1'b0 || grant_o !== 2'b00 || mem_write_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: en=%b grant=%b wr=%b, want 0 00 0", mem_enable_o, grant_o, mem_write_o);
        end
        checks++;
        if (mem_addr_o !== '0 || mem_data_o !== '0 || m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_data: addr=%h ack0=%b ack1=%b, want 0 0 0", mem_addr_o, m0_ack_o, m1_ack_o);
        end
        rst_i = 1'b1;
        tick();
    endtask

    // m0 read at address 0, memory answers 256'h5 after ten cycles
    task automatic test_read();
        int bad_hold = 0;
        m0_enable_i = 1; m0_write_i = 0; m0_addr_i = 32'h0;
        tick();
        checks++;
        if (mem_enable_o !== 1'b1 || grant_o !== 2'b01 || mem_write_o !== 1'b0 || mem_addr_o !== 32'h0) begin
            failures++;
            $display("FAIL read_grant: en=%b grant=%b wr=%b addr=%h, want 1 01 0 0", mem_enable_o, grant_o, mem_write_o, mem_addr_o);
        end
        for (int i = 0; i < 9; i++) begin
            tick();
            if (mem_enable_o !== 1'b1 || m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0) bad_hold++;
        end
        checks++;
        if (bad_hold != 0) begin
            failures++;
            $display("FAIL read_wait: %0d bad cycles, want 0", bad_hold);
        end
        mem_ack_i = 1; mem_data_i = 256'h5;
        #1;
        checks++;
        if (m0_ack_o !== 1'b1 || m0_data_o !== 256'h5 || m1_ack_o !== 1'b0) begin
            failures++;
            $display("FAIL read_ack: ack0=%b data0=%h ack1=%b, want 1 5 0", m0_ack_o, m0_data_o, m1_ack_o);
        end
        tick();
        mem_ack_i = 0; m0_enable_i = 0;
        #1;
        checks++;
        if (mem_enable_o !== 1'b0 || grant_o !== 2'b00 || m0_ack_o !== 1'b0) begin
            failures++;
            $display("FAIL read_release: en=%b grant=%b ack0=%b, want 0 00 0", mem_enable_o, grant_o, m0_ack_o);
        end
        tick();
    endtask

    // Simultaneous requests: winner first, one IDLE cycle, then the other
    task automatic test_priority();
        logic [1:0]        g_first, g_second;
        logic [ADDR_W-1:0] a_first, a_second;
`ifdef MEM_ARB_RR_EN
        // m0 owned the port last (test_read), so m1 wins the tie
        g_first = 2'b10; a_first = 32'h200; g_second = 2'b01; a_second = 32'h100;
`else
        g_first = 2'b01; a_first = 32'h100; g_second = 2'b10; a_second = 32'h200;
`endif
        m0_enable_i = 1; m0_addr_i = 32'h100; m0_write_i = 0;
        m1_enable_i = 1; m1_addr_i = 32'h200; m1_write_i = 0;
        tick();
        checks++;
        if (grant_o !== g_first || mem_addr_o !== a_first) begin
            failures++;
            $display("FAIL prio_first: grant=%b addr=%h, want %b %h", grant_o, mem_addr_o, g_first, a_first);
        end
        mem_ack_i = 1;
        tick();
        mem_ack_i = 0;
        if (g_first == 2'b01) m0_enable_i = 0; else m1_enable_i = 0;
        #1;
        checks++;
        if (grant_o !== 2'b00 || mem_enable_o !== 1'b0) begin
            failures++;
            $display("FAIL prio_idle_gap: grant=%b en=%b, want 00 0", grant_o, mem_enable_o);
        end
        tick();
        checks++;
        if (grant_o !== g_second || mem_addr_o !== a_second || mem_enable_o !== 1'b1) begin
            failures++;
            $display("FAIL prio_second: grant=%b addr=%h en=%b, want %b %h 1", grant_o, mem_addr_o, mem_enable_o, g_second, a_second);
        end
        mem_ack_i = 1;
        tick();
        mem_ack_i = 0; m0_enable_i = 0; m1_enable_i = 0;
        tick();
    endtask

    // m1 write; address changes and enable drops mid-grant
    task automatic test_write_hold();
        int bad = 0;
        m1_enable_i = 1; m1_write_i = 1; m1_addr_i = 32'h400; m1_data_i = 256'hA5;
        tick();
        checks++;
        if (grant_o !== 2'b10 || mem_addr_o !== 32'h400 || mem_write_o !== 1'b1 || mem_data_o !== 256'hA5) begin
            failures++;
            $display("FAIL write_grant: grant=%b addr=%h wr=%b data=%h, want 10 400 1 a5", grant_o, mem_addr_o, mem_write_o, mem_data_o);
        end
        m1_addr_i = 32'h0; m1_data_i = '0; m1_write_i = 0; m1_enable_i = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (mem_addr_o !== 32'h400 || mem_write_o !== 1'b1 || mem_data_o !== 256'hA5 || mem_enable_o !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL write_hold: %0d bad cycles, want 0", bad);
        end
        mem_ack_i = 1;
        #1;
        checks++;
        if (m1_ack_o !== 1'b1 || m0_ack_o !== 1'b0) begin
            failures++;
            $display("FAIL write_ack: ack1=%b ack0=%b, want 1 0", m1_ack_o, m0_ack_o);
        end
        tick();
        mem_ack_i = 0;
        #1;
        checks++;
        if (mem_addr_o !== '0 || mem_data_o !== '0 || mem_write_o !== 1'b0 || mem_enable_o !== 1'b0) begin
            failures++;
            $display("FAIL write_idle_clear: addr=%h wr=%b en=%b, want 0 0 0", mem_addr_o, mem_write_o, mem_enable_o);
        end
        tick();
    endtask

    // Reset three cycles into GNT0 while memory acks
    task automatic test_reset_mid();
        m0_enable_i = 1; m0_addr_i = 32'h80; m0_write_i = 0;
        tick(); tick(); tick();
        rst_i = 0; mem_ack_i = 1; m0_enable_i = 0;
        #1;
        checks++;
        if (m0_ack_o !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_during: ack0=%b, want 0", m0_ack_o);
        end
        tick();
        rst_i = 1;
        #1;
        checks++;
        if (m0_ack_o !== 1'b0 || mem_enable_o !== 1'b0 || grant_o !== 2'b00) begin
            failures++;
            $display("FAIL rstmid_after: ack0=%b en=%b grant=%b, want 0 0 00", m0_ack_o, mem_enable_o, grant_o);
        end
        mem_ack_i = 0;
        tick();
    endtask

    // Memory ack with no grant outstanding
    task automatic test_idle_ack();
        mem_ack_i = 1;
        #1;
        checks++;
        if (m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0) begin
            failures++;
            $display("FAIL idle_ack: ack0=%b ack1=%b, want 0 0", m0_ack_o, m1_ack_o);
        end
        tick();
        mem_ack_i = 0;
        checks++;
        if (grant_o !== 2'b00 || mem_enable_o !== 1'b0) begin
            failures++;
            $display("FAIL idle_stay: grant=%b en=%b, want 00 0", grant_o, mem_enable_o);
        end
    endtask

    // Both requesters held for four transactions; last owner is m1 after reset
    task automatic test_back_to_back();
        logic [1:0] exp_g [4];
        logic       ack_ok;
`ifdef MEM_ARB_RR_EN
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        m0_enable_i = 1; m1_enable_i = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (grant_o !== exp_g[i] || mem_enable_o !== 1'b1) begin
                failures++;
                $display("FAIL b2b_grant%0d: grant=%b en=%b, want %b 1", i, grant_o, mem_enable_o, exp_g[i]);
            end
            mem_ack_i = 1;
            #1;
            ack_ok = (m0_ack_o === exp_g[i][0]) && (m1_ack_o === exp_g[i][1]);
            checks++;
            if (!ack_ok) begin
                failures++;
                $display("FAIL b2b_ack%0d: ack={%b,%b}, want %b", i, m1_ack_o, m0_ack_o, exp_g[i]);
            end
            tick();
            mem_ack_i = 0;
            checks++;
            if (grant_o !== 2'b00 || mem_enable_o !== 1'b0) begin
                failures++;
                $display("FAIL b2b_gap%0d: grant=%b en=%b, want 00 0", i, grant_o, mem_enable_o);
            end
        end
        m0_enable_i = 0; m1_enable_i = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_read();
        test_priority();
        test_write_hold();
        test_reset_mid();
        test_idle_ack();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, 32, address width; DATA_W, 256, cache-line width.
REQ-002 Reset SHALL be synchronous and active-low; the block SHALL have one clock.
REQ-003 Port clk_i  input  1  clock; all state changes on rising edge.
REQ-004 Port rst_i  input  1  synchronous active-low reset.
REQ-005 Ports m0_enable_i/m0_write_i  input  1 each  requester 0 (dcache) request and write flag.
REQ-006 Ports m0_addr_i  input  ADDR_W, m0_data_i  input  DATA_W  requester 0 address and write line.
REQ-007 Ports m0_ack_o  output  1, m0_data_o  output  DATA_W  requester 0 completion and read line.
REQ-008 Ports m1_enable_i, m1_write_i, m1_addr_i, m1_data_i, m1_ack_o, m1_data_o SHALL mirror the m0_* ports (requester 1, instruction fetch).
REQ-009 Ports mem_enable_o, mem_write_o  output  1; mem_addr_o  output  ADDR_W; mem_data_o  output  DATA_W  shared Data_Memory port.
REQ-010 Ports mem_ack_i  input  1, mem_data_i  input  DATA_W  memory completion and read line.
REQ-011 Port grant_o  output  2  one-hot owner {m1,m0}; 2'b00 when idle.

Function
REQ-012 FSM states SHALL be IDLE, GNT0, GNT1.
REQ-013 In IDLE with any request, next state SHALL be GNT0 or GNT1 per the arbitration rule; no request -> stay IDLE.
REQ-014 On entering GNTx, addr/data/write of requester x SHALL be registered into mem_addr_o/mem_data_o/mem_write_o and held constant until exit.
REQ-015 mem_enable_o SHALL be 1 exactly while in GNT0/GNT1 (registered; first high cycle = cycle after request sampled).
REQ-016 In GNTx, mem_ack_i sampled 1 SHALL return FSM to IDLE; mem_enable_o low the following cycle.
REQ-017 mx_ack_o SHALL equal mem_ack_i AND (state==GNTx), combinational; non-owner ack SHALL stay 0.
REQ-018 mx_data_o SHALL pass mem_data_i unmodified to both requesters; validity is qualified only by mx_ack_o.
REQ-019 After every completion the FSM SHALL spend at least one cycle in IDLE (mem_enable_o low) before the next grant.
REQ-020 Requesters SHALL hold enable until their ack; if mx_enable_i drops mid-grant, the transaction SHALL still complete and be acked.
REQ-021 mem_ack_i while IDLE SHALL be ignored, no ack output.
REQ-022 In IDLE, mem_addr_o, mem_data_o, mem_write_o SHALL be 0.
REQ-023 Fixed priority (default): simultaneous requests -> m0 granted.

Reset
REQ-024 rst_i low at a rising edge SHALL force IDLE, mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0, grant_o=0, last-owner=m1.
REQ-025 Reset mid-transaction SHALL abandon it; no mx_ack_o SHALL be raised during or for the cycle following reset, even if mem_ack_i=1.

Configuration
REQ-026 Macro MEM_ARB_RR_EN defined: round-robin; on simultaneous requests the requester not granted last SHALL win; single request granted regardless.
REQ-027 Macro MEM_ARB_RR_EN undefined: fixed priority per REQ-023; last-owner register SHALL not be built.

Verification
REQ-028 m0 read addr 0x00000000, memory returns 256'h5 after 10 cycles -> mem_enable_o high 1 cycle after request, m0_ack_o one pulse, m0_data_o=256'h5, m1_ack_o=0.
REQ-029 m0 and m1 request same cycle, no macro -> GNT0 first; after m0 ack, one IDLE cycle, then GNT1 with mem_addr_o=m1_addr_i.
REQ-030 MEM_ARB_RR_EN, both requesters held continuously for 4 transactions -> grant order m0,m1,m0,m1.
REQ-031 m1 write addr 0x00000400 data 256'hA5; m1_addr_i changed to 0x0 mid-grant -> mem_addr_o stays 0x400, mem_write_o=1 until ack.
REQ-032 rst_i low 3 cycles into GNT0, mem_ack_i=1 next cycle -> state IDLE, mem_enable_o=0, m0_ack_o=0, grant_o=00.
REQ-033 mem_ack_i pulsed in IDLE with no requests -> no mx_ack_o, state remains IDLE.
